// File: rtl/front_panel_sequencer_if.sv
// Command handshake between a host transactor or boot streamer and the front-panel sequencer.
interface front_panel_sequencer_if;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 12;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_done;
    logic              run_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, cmd_done, run_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, cmd_done, run_timeout
    );
endinterface

// File: rtl/front_panel_sequencer.sv
// Drives PDP-8 front-panel switches/buttons from a command stream: load PC, deposit, run.
// One down-counter times switch setup, button press, release gap and the run watchdog.
module front_panel_sequencer #(
    parameter int SETUP_CYCLES   = 10,
    parameter int PRESS_CYCLES   = 10,
    parameter int RELEASE_CYCLES = 10,
    parameter int RUN_TIMEOUT    = 0
) (
    input  logic                   clock,
    input  logic                   resetN,
    front_panel_sequencer_if.slave cmd,
    input  logic                   run_led,
    output logic [12:0]            sw,
    output logic                   btnd,
    output logic                   btnl,
    output logic [11:0]            deposit_count
);
    localparam int unsigned DATA_W  = 12;
    localparam int          MAX_SP  = (SETUP_CYCLES > PRESS_CYCLES) ? SETUP_CYCLES : PRESS_CYCLES;
    localparam int          MAX_RT  = (RELEASE_CYCLES > RUN_TIMEOUT) ? RELEASE_CYCLES : RUN_TIMEOUT;
    localparam int          MAX_ALL = (MAX_SP > MAX_RT) ? MAX_SP : MAX_RT;
    localparam int unsigned CNT_W   = (MAX_ALL < 2) ? 1 : $clog2(MAX_ALL);

    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_PRESS   = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RELEASE = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TO      = CNT_W'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
    localparam bit               TO_EN      = (RUN_TIMEOUT > 0);

    if (SETUP_CYCLES < 1 || PRESS_CYCLES < 1 || RELEASE_CYCLES < 1 || RUN_TIMEOUT < 0) begin : g_bad_param
        $error("front_panel_sequencer: SETUP/PRESS/RELEASE_CYCLES must be >= 1, RUN_TIMEOUT >= 0");
    end

    typedef enum logic [1:0] {
        OP_LOAD_PC = 2'b00,
        OP_DEPOSIT = 2'b01,
        OP_RUN     = 2'b10,
        OP_NOP     = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PRESS,
        S_RELEASE,
        S_RUN_START,
        S_RUN_WAIT
    } state_e;

    state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_dec;
    logic                r_is_dep, w_is_dep_nxt;
    logic [12:0]         r_sw, w_sw_nxt;
    logic                r_btnd, w_btnd_nxt;
    logic                r_btnl, w_btnl_nxt;
    logic                r_done, w_done_nxt;
    logic                r_to, w_to_nxt;
    logic [DATA_W-1:0]   r_dcnt, w_dcnt_nxt;
    logic                r_ready;
    logic                w_cnt_zero;
    logic                w_expire;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    assign w_expire   = TO_EN && w_cnt_zero;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_dep_nxt = r_is_dep;
        w_sw_nxt     = r_sw;
        w_btnd_nxt   = r_btnd;
        w_btnl_nxt   = r_btnl;
        w_done_nxt   = 1'b0;
        w_to_nxt     = 1'b0;
        w_dcnt_nxt   = r_dcnt;

        case (r_state)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    case (op_e'(cmd.cmd_op))
                        OP_LOAD_PC, OP_DEPOSIT: begin
                            w_sw_nxt[11:0] = cmd.cmd_data;
                            w_is_dep_nxt   = (op_e'(cmd.cmd_op) == OP_DEPOSIT);
                            w_cnt_nxt      = LD_SETUP;
                            w_state_nxt    = S_SETUP;
                        end
                        OP_RUN: begin
                            w_sw_nxt[12] = 1'b1;
                            w_cnt_nxt    = LD_TO;
                            w_state_nxt  = S_RUN_START;
                        end
                        default: w_done_nxt = 1'b1;
                    endcase
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_btnd_nxt  = r_is_dep;
                    w_btnl_nxt  = !r_is_dep;
                    w_cnt_nxt   = LD_PRESS;
                    w_state_nxt = S_PRESS;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_PRESS: begin
                if (w_cnt_zero) begin
                    w_btnd_nxt  = 1'b0;
                    w_btnl_nxt  = 1'b0;
                    w_cnt_nxt   = LD_RELEASE;
                    w_state_nxt = S_RELEASE;
                    if (r_is_dep) begin
                        w_dcnt_nxt = r_dcnt + DATA_W'(1);
                    end
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_RELEASE: begin
                if (w_cnt_zero) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_RUN_START: begin
                if (run_led) begin
                    w_cnt_nxt   = LD_TO;
                    w_state_nxt = S_RUN_WAIT;
                end else if (w_expire) begin
                    w_sw_nxt[12] = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_to_nxt     = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (TO_EN) begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_RUN_WAIT: begin
                if (!run_led) begin
                    w_sw_nxt[12] = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (w_expire) begin
                    w_sw_nxt[12] = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_to_nxt     = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (TO_EN) begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset drops buttons and the run switch at once
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_dep <= 1'b0;
            r_sw     <= '0;
            r_btnd   <= 1'b0;
            r_btnl   <= 1'b0;
            r_done   <= 1'b0;
            r_to     <= 1'b0;
            r_dcnt   <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_dep <= w_is_dep_nxt;
            r_sw     <= w_sw_nxt;
            r_btnd   <= w_btnd_nxt;
            r_btnl   <= w_btnl_nxt;
            r_done   <= w_done_nxt;
            r_to     <= w_to_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_ready  <= (w_state_nxt == S_IDLE);
        end
    end

    assign cmd.cmd_ready   = r_ready;
    assign cmd.cmd_done    = r_done;
    assign cmd.run_timeout = r_to;
    assign sw              = r_sw;
    assign btnd            = r_btnd;
    assign btnl            = r_btnl;
    assign deposit_count   = r_dcnt;
endmodule

// File: tb/tb_front_panel_sequencer.sv
// Bench for front_panel_sequencer: timing model derived from command rules, front-panel memory model, run LED model.
module tb_front_panel_sequencer;
    localparam int SA = 10, PA = 10, RA = 10, TOA = 50;
    localparam logic [1:0] C_LOAD = 2'b00, C_DEP = 2'b01, C_RUN = 2'b10, C_NOP = 2'b11;

    logic        clock = 1'b0;
    logic        resetN;
    logic        run_led_a, run_led_b;
    logic [12:0] sw_a, sw_b;
    logic        btnd_a, btnl_a, btnd_b, btnl_b;
    logic [11:0] dcnt_a, dcnt_b;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] m_sw_a, m_dcnt_a, m_sw_b;
    logic [1:0]  q_op[$];
    logic [11:0] q_dat[$];
    int          led_rise = 5, led_hi = 100;

    always #5 clock = ~clock;

    front_panel_sequencer_if ifa();
    front_panel_sequencer_if ifb();

    front_panel_sequencer #(
        .SETUP_CYCLES(SA), .PRESS_CYCLES(PA), .RELEASE_CYCLES(RA), .RUN_TIMEOUT(TOA)
    ) u_dut_a (
        .clock(clock), .resetN(resetN), .cmd(ifa), .run_led(run_led_a),
        .sw(sw_a), .btnd(btnd_a), .btnl(btnl_a), .deposit_count(dcnt_a)
    );

    front_panel_sequencer #(
        .SETUP_CYCLES(1), .PRESS_CYCLES(1), .RELEASE_CYCLES(1), .RUN_TIMEOUT(0)
    ) u_dut_b (
        .clock(clock), .resetN(resetN), .cmd(ifb), .run_led(run_led_b),
        .sw(sw_b), .btnd(btnd_b), .btnl(btnl_b), .deposit_count(dcnt_b)
    );

    // Front panel of DUT A: load-PC latches the address, deposit writes and bumps it
    logic [11:0] fp_mem [4096];
    logic [11:0] fp_pc;
    logic        fp_btnd_q, fp_btnl_q;
    always @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < 4096; i++) fp_mem[i] <= 12'o5555;
            fp_pc     <= '0;
            fp_btnd_q <= 1'b0;
            fp_btnl_q <= 1'b0;
        end else begin
            fp_btnd_q <= btnd_a;
            fp_btnl_q <= btnl_a;
            if (btnl_a && !fp_btnl_q) fp_pc <= sw_a[11:0];
            if (btnd_a && !fp_btnd_q) begin
                fp_mem[fp_pc] <= sw_a[11:0];
                fp_pc         <= fp_pc + 12'd1;
            end
        end
    end

    // CPU of DUT B: LED rises led_rise cycles after the run switch, stays on led_hi cycles
    int led_cnt;
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            run_led_b <= 1'b0;
            led_cnt   <= 0;
        end else if (!sw_b[12]) begin
            run_led_b <= 1'b0;
            led_cnt   <= 0;
        end else begin
            led_cnt <= led_cnt + 1;
            if (led_cnt + 1 == led_rise) run_led_b <= 1'b1;
            else if (led_cnt + 1 == led_rise + led_hi) run_led_b <= 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams queued LOAD/DEPOSIT/NOP commands into A with cmd_valid held throughout
    task automatic a_stream();
        int          n, d;
        logic [1:0]  op;
        logic [11:0] dat, esw, edc;
        n = q_op.size();
        chk("a_ready_idle", 32'(ifa.cmd_ready), 32'd1);
        ifa.cmd_valid = 1'b1;
        ifa.cmd_op    = q_op[0];
        ifa.cmd_data  = q_dat[0];
        for (int i = 0; i < n; i++) begin
            op  = q_op[i];
            dat = q_dat[i];
            @(negedge clock);
            if (i == n - 1) ifa.cmd_valid = 1'b0;
            else begin
                ifa.cmd_op   = q_op[i+1];
                ifa.cmd_data = q_dat[i+1];
            end
            d   = (op == C_NOP) ? 0 : SA + PA + RA;
            esw = (op == C_NOP) ? m_sw_a : dat;
            for (int t = 0; t <= d; t++) begin
                if (t > 0) @(negedge clock);
                edc = m_dcnt_a + ((op == C_DEP && t >= SA + PA) ? 12'd1 : 12'd0);
                chk("a_done",  32'(ifa.cmd_done), 32'(t == d));
                chk("a_ready", 32'(ifa.cmd_ready), 32'(t == d));
                chk("a_btnl",  32'(btnl_a), 32'(op == C_LOAD && t >= SA && t < SA + PA));
                chk("a_btnd",  32'(btnd_a), 32'(op == C_DEP && t >= SA && t < SA + PA));
                chk("a_sw",    32'(sw_a), 32'({1'b0, esw}));
                chk("a_dcnt",  32'(dcnt_a), 32'(edc));
                chk("a_rto",   32'(ifa.run_timeout), 32'd0);
            end
            m_sw_a = esw;
            if (op == C_DEP) m_dcnt_a = m_dcnt_a + 12'd1;
        end
        q_op.delete();
        q_dat.delete();
    endtask

    // RUN on A with the LED held at a fixed level, so only the watchdog can end it
    task automatic a_run_timeout(input logic led);
        int d;
        run_led_a = led;
        chk("a_run_ready", 32'(ifa.cmd_ready), 32'd1);
        ifa.cmd_valid = 1'b1;
        ifa.cmd_op    = C_RUN;
        ifa.cmd_data  = 12'($urandom);
        @(negedge clock);
        ifa.cmd_valid = 1'b0;
        d = TOA + (led ? 1 : 0);
        for (int t = 0; t <= d; t++) begin
            if (t > 0) @(negedge clock);
            chk("a_run_sw12", 32'(sw_a[12]), 32'(t < d));
            chk("a_run_swlo", 32'(sw_a[11:0]), 32'(m_sw_a));
            chk("a_run_done", 32'(ifa.cmd_done), 32'(t == d));
            chk("a_run_to",   32'(ifa.run_timeout), 32'(t == d));
            chk("a_run_btn",  32'({btnd_a, btnl_a}), 32'd0);
        end
        run_led_a = 1'b0;
        @(negedge clock);
        chk("a_run_after_done", 32'({ifa.cmd_done, ifa.run_timeout, sw_a[12]}), 32'd0);
    endtask

    // RUN on B against the LED model; ends one edge after the LED falls
    task automatic b_run(input int rise, input int hi);
        int d;
        led_rise = rise;
        led_hi   = hi;
        chk("b_run_ready", 32'(ifb.cmd_ready), 32'd1);
        ifb.cmd_valid = 1'b1;
        ifb.cmd_op    = C_RUN;
        ifb.cmd_data  = 12'($urandom);
        @(negedge clock);
        ifb.cmd_valid = 1'b0;
        d = rise + hi + 1;
        for (int t = 0; t <= d; t++) begin
            if (t > 0) @(negedge clock);
            chk("b_run_sw12",  32'(sw_b[12]), 32'(t < d));
            chk("b_run_swlo",  32'(sw_b[11:0]), 32'(m_sw_b));
            chk("b_run_done",  32'(ifb.cmd_done), 32'(t == d));
            chk("b_run_ready", 32'(ifb.cmd_ready), 32'(t == d));
            chk("b_run_to",    32'(ifb.run_timeout), 32'd0);
        end
    endtask

    initial begin
        logic [11:0] r0, r1, r2, r3, pre_dat, dat;
        int          ndone, cyc;

        resetN = 1'b0;
        run_led_a = 1'b0;
        ifa.cmd_valid = 1'b0; ifa.cmd_op = C_NOP; ifa.cmd_data = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_op = C_NOP; ifb.cmd_data = '0;
        m_sw_a = '0; m_dcnt_a = '0; m_sw_b = '0;
        repeat (3) @(negedge clock);

        chk("rst_sw_a",    32'(sw_a), 32'd0);
        chk("rst_btn_a",   32'({btnd_a, btnl_a}), 32'd0);
        chk("rst_done_a",  32'({ifa.cmd_done, ifa.run_timeout}), 32'd0);
        chk("rst_dcnt_a",  32'(dcnt_a), 32'd0);
        chk("rst_ready_a", 32'(ifa.cmd_ready), 32'd1);
        chk("rst_sw_b",    32'(sw_b), 32'd0);
        chk("rst_ready_b", 32'(ifb.cmd_ready), 32'd1);
        resetN = 1'b1;
        @(negedge clock);

        q_op.push_back(C_LOAD); q_dat.push_back(12'o0200);
        a_stream();

        q_op.push_back(C_DEP); q_dat.push_back(12'o7001);
        q_op.push_back(C_DEP); q_dat.push_back(12'o1234);
        q_op.push_back(C_DEP); q_dat.push_back(12'o0000);
        a_stream();
        chk("dep3_count", 32'(dcnt_a), 32'd3);
        chk("mem_0200", 32'(fp_mem[12'o0200]), 32'(12'o7001));
        chk("mem_0201", 32'(fp_mem[12'o0201]), 32'(12'o1234));
        chk("mem_0202", 32'(fp_mem[12'o0202]), 32'(12'o0000));

        r0 = 12'($urandom); r1 = 12'($urandom); r2 = 12'($urandom); r3 = 12'($urandom);
        q_op.push_back(C_LOAD); q_dat.push_back(r0);
        q_op.push_back(C_DEP);  q_dat.push_back(r1);
        q_op.push_back(C_NOP);  q_dat.push_back(12'($urandom));
        q_op.push_back(C_DEP);  q_dat.push_back(r2);
        q_op.push_back(C_DEP);  q_dat.push_back(r3);
        a_stream();
        chk("mem_rand0", 32'(fp_mem[r0]), 32'(r1));
        chk("mem_rand1", 32'(fp_mem[12'(r0 + 12'd1)]), 32'(r2));
        chk("mem_rand2", 32'(fp_mem[12'(r0 + 12'd2)]), 32'(r3));

        a_run_timeout(1'b0);
        a_run_timeout(1'b1);

        // Reset in the middle of a deposit press
        chk("rstp_ready", 32'(ifa.cmd_ready), 32'd1);
        ifa.cmd_valid = 1'b1; ifa.cmd_op = C_DEP; ifa.cmd_data = 12'($urandom);
        @(negedge clock);
        ifa.cmd_valid = 1'b0;
        repeat (SA + 3) @(negedge clock);
        chk("rstp_btnd_on", 32'(btnd_a), 32'd1);
        chk("rstp_dcnt_hold", 32'(dcnt_a), 32'(m_dcnt_a));
        resetN = 1'b0;
        #1;
        chk("rstp_btnd_off", 32'(btnd_a), 32'd0);
        chk("rstp_sw", 32'(sw_a), 32'd0);
        chk("rstp_done", 32'(ifa.cmd_done), 32'd0);
        chk("rstp_dcnt", 32'(dcnt_a), 32'd0);
        chk("rstp_ready_in_rst", 32'(ifa.cmd_ready), 32'd1);
        @(negedge clock);
        resetN = 1'b1;
        m_sw_a = '0; m_dcnt_a = '0; m_sw_b = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rstp_quiet", 32'({ifa.cmd_done, btnd_a, btnl_a}), 32'd0);
            chk("rstp_dcnt_after", 32'(dcnt_a), 32'd0);
        end
        chk("rstp_ready_after", 32'(ifa.cmd_ready), 32'd1);
        ifa.cmd_valid = 1'b1; ifa.cmd_op = C_NOP;
        @(negedge clock);
        ifa.cmd_valid = 1'b0;
        chk("nop_done", 32'(ifa.cmd_done), 32'd1);
        chk("nop_ready", 32'(ifa.cmd_ready), 32'd1);
        chk("nop_sw", 32'(sw_a), 32'd0);
        @(negedge clock);
        chk("nop_done_clr", 32'(ifa.cmd_done), 32'd0);

        b_run(5, 100);
        b_run(int'($urandom_range(1, 8)), int'($urandom_range(1, 60)));
        b_run(1, 1);

        // Preload B's deposit counter to 4095 with valid held high
        pre_dat = 12'($urandom);
        ifb.cmd_op = C_DEP; ifb.cmd_data = pre_dat; ifb.cmd_valid = 1'b1;
        ndone = 0; cyc = 0;
        while (ndone < 4095 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (ifb.cmd_done) begin
                ndone++;
                if (ndone == 4095) ifb.cmd_valid = 1'b0;
            end
        end
        ifb.cmd_valid = 1'b0;
        m_sw_b = pre_dat;
        chk("pre_ndone", 32'(ndone), 32'd4095);
        chk("pre_dcnt", 32'(dcnt_b), 32'hFFF);
        chk("pre_sw", 32'(sw_b), 32'({1'b0, m_sw_b}));

        // Final deposit wraps the count; a valid pulse during SETUP must be ignored
        dat = ~pre_dat;
        chk("wrap_ready", 32'(ifb.cmd_ready), 32'd1);
        ifb.cmd_valid = 1'b1; ifb.cmd_op = C_DEP; ifb.cmd_data = dat;
        @(negedge clock);
        ifb.cmd_op = C_LOAD; ifb.cmd_data = 12'($urandom);
        for (int t = 0; t <= 3; t++) begin
            if (t > 0) @(negedge clock);
            if (t == 1) ifb.cmd_valid = 1'b0;
            chk("wrap_btnd", 32'(btnd_b), 32'(t == 1));
            chk("wrap_btnl", 32'(btnl_b), 32'd0);
            chk("wrap_done", 32'(ifb.cmd_done), 32'(t == 3));
            chk("wrap_sw",   32'(sw_b), 32'({1'b0, dat}));
            chk("wrap_dcnt", 32'(dcnt_b), (t >= 2) ? 32'd0 : 32'hFFF);
        end
        @(negedge clock);
        chk("wrap_after_quiet", 32'({ifb.cmd_done, btnd_b, btnl_b}), 32'd0);
        chk("wrap_after_dcnt", 32'(dcnt_b), 32'd0);
        chk("wrap_after_sw", 32'(sw_b), 32'({1'b0, dat}));
        chk("wrap_after_ready", 32'(ifb.cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
